neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_pkg.sv | 34 +++
 rtl/neuron_activation.sv | 78 +++++++
 rtl/neuron_mac.sv | 119 +++++++++++
 tb/tb_neuron_mac.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC datapath and its activation unit.
package neuron_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_ACT  = 2'd2
   } state_e;

   // Activation select encodings (both 1x codes mean linear)
   localparam logic [1:0] MODE_SIGMOID    = 2'b00;
   localparam logic [1:0] MODE_RELU       = 2'b01;
   localparam logic [1:0] MODE_LINEAR     = 2'b10;
   localparam logic [1:0] MODE_LINEAR_ALT = 2'b11;

   // PLAN sigmoid breakpoints, expressed in eighths (5.0, 2.375, 1.0)
   localparam int unsigned SIG_BP_FRAC = 3;
   localparam int unsigned SIG_BP_SAT  = 40;
   localparam int unsigned SIG_BP_HI   = 19;
   localparam int unsigned SIG_BP_MID  = 8;

   // Segment offsets in 32nds (0.84375, 0.625, 0.5)
   localparam int unsigned SIG_EXTRA_FRAC = 5;
   localparam int unsigned SIG_OFF_HI     = 27;
   localparam int unsigned SIG_OFF_MID    = 20;
   localparam int unsigned SIG_OFF_LO     = 16;

   // Segment slopes as left shifts in the 32nds domain (1/32, 1/8, 1/4)
   localparam int unsigned SIG_SHIFT_HI  = 0;
   localparam int unsigned SIG_SHIFT_MID = 2;
   localparam int unsigned SIG_SHIFT_LO  = 3;

endpackage

// File: rtl/neuron_activation.sv
// Combinational activation: saturates a wide z to DATA_WIDTH and applies
// sigmoid (PLAN), ReLU or linear.
module neuron_activation
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int Z_WIDTH    = 20
) (
   input  logic signed [Z_WIDTH-1:0]    z,
   input  logic        [1:0]            mode,
   output logic signed [DATA_WIDTH-1:0] y
);

   // Working width for the sigmoid math: magnitude scaled by 8 plus offsets
   localparam int SW = DATA_WIDTH + 6;
   localparam logic signed [Z_WIDTH-1:0] Z_MIN = {Z_WIDTH{1'b1}} << (DATA_WIDTH-1);
   localparam logic signed [Z_WIDTH-1:0] Z_MAX = ~Z_MIN;

   logic signed [DATA_WIDTH-1:0] z_sat;
   logic signed [DATA_WIDTH:0]   z_ext;
   logic        [DATA_WIDTH:0]   mag;
   logic        [SW-1:0]         mag_w;
   logic        [SW-1:0]         mag_8ths;
   logic        [SW-1:0]         one_w;
   logic        [SW-1:0]         sum;
   logic        [SW-1:0]         f_full;
   logic        [DATA_WIDTH-1:0] f_small;
   logic        [DATA_WIDTH-1:0] one_dw;
   logic        [DATA_WIDTH-1:0] sig_y;

   // Clamp z into the output range before any activation is applied
   always_comb begin
      z_sat = z[DATA_WIDTH-1:0];
      if (z > Z_MAX) begin
         z_sat = Z_MAX[DATA_WIDTH-1:0];
      end else if (z < Z_MIN) begin
         z_sat = Z_MIN[DATA_WIDTH-1:0];
      end
   end

   // Piecewise-linear sigmoid on |z|; the extra bit on mag holds |-2^(N-1)|
   always_comb begin
      z_ext    = {z_sat[DATA_WIDTH-1], z_sat};
      mag      = z_ext[DATA_WIDTH] ? -z_ext : z_ext;
      mag_w    = {{(SW-DATA_WIDTH-1){1'b0}}, mag};
      mag_8ths = mag_w << SIG_BP_FRAC;
      one_w    = {{(SW-1){1'b0}}, 1'b1} << FRAC_BITS;
      if (mag_8ths >= (SW'(SIG_BP_HI) << FRAC_BITS)) begin
         sum = (mag_w << SIG_SHIFT_HI) + (SW'(SIG_OFF_HI) << FRAC_BITS);
      end else if (mag_8ths >= (SW'(SIG_BP_MID) << FRAC_BITS)) begin
         sum = (mag_w << SIG_SHIFT_MID) + (SW'(SIG_OFF_MID) << FRAC_BITS);
      end else begin
         sum = (mag_w << SIG_SHIFT_LO) + (SW'(SIG_OFF_LO) << FRAC_BITS);
      end
      f_full = sum >> SIG_EXTRA_FRAC;
      one_dw = one_w[DATA_WIDTH-1:0];
      if ((mag_8ths >= (SW'(SIG_BP_SAT) << FRAC_BITS)) || (f_full > one_w)) begin
         f_small = one_dw;
      end else begin
         f_small = f_full[DATA_WIDTH-1:0];
      end
      sig_y = z_sat[DATA_WIDTH-1] ? (one_dw - f_small) : f_small;
   end

   // Final activation select
   always_comb begin
      y = z_sat;
      case (mode)
         MODE_SIGMOID:    y = sig_y;
         MODE_RELU:       y = z_sat[DATA_WIDTH-1] ? '0 : z_sat;
         MODE_LINEAR:     y = z_sat;
         MODE_LINEAR_ALT: y = z_sat;
         default:         y = z_sat;
      endcase
   end

endmodule

// File: rtl/neuron_mac.sv
// Sequential single-neuron MAC: bias preload, one multiply-accumulate per
// input, then a registered activation step with a Done pulse.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int N_INPUTS   = 2,
   parameter logic [N_INPUTS*DATA_WIDTH-1:0] W = {DATA_WIDTH'(60), DATA_WIDTH'(51)},
   parameter logic signed [DATA_WIDTH-1:0]   BIAS = DATA_WIDTH'(-13)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           En,
   input  logic                           Run,
   input  logic [N_INPUTS*DATA_WIDTH-1:0] X,
   input  logic [1:0]                     Mode,
   output logic                           Busy,
   output logic                           Done,
   output logic signed [DATA_WIDTH-1:0]   Y
);

   localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N_INPUTS) + 1;
   localparam int IDX_WIDTH = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(N_INPUTS-1);
   localparam logic signed [ACC_WIDTH-1:0] ACC_INIT = ACC_WIDTH'(BIAS) <<< FRAC_BITS;

   state_e                           state;
   state_e                           state_next;
   logic [IDX_WIDTH-1:0]             idx;
   logic signed [ACC_WIDTH-1:0]      acc;
   logic [N_INPUTS*DATA_WIDTH-1:0]   xr;
   logic [1:0]                       mode_r;
   logic signed [DATA_WIDTH-1:0]     y_r;
   logic                             done_r;
   logic signed [DATA_WIDTH-1:0]     x_sel;
   logic signed [DATA_WIDTH-1:0]     w_sel;
   logic signed [2*DATA_WIDTH-1:0]   prod;
   logic signed [ACC_WIDTH-1:0]      prod_ext;
   logic signed [ACC_WIDTH-1:0]      z;
   logic signed [DATA_WIDTH-1:0]     act_y;

   // Current term of the dot product, full-precision and sign-extended
   always_comb begin
      x_sel    = $signed(xr[idx*DATA_WIDTH +: DATA_WIDTH]);
      w_sel    = $signed(W[idx*DATA_WIDTH +: DATA_WIDTH]);
      prod     = x_sel * w_sel;
      prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      z        = acc >>> FRAC_BITS;
   end

   neuron_activation #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .Z_WIDTH    (ACC_WIDTH)
   ) u_act (
      .z    (z),
      .mode (mode_r),
      .y    (act_y)
   );

   // State register; only advances on enabled edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (En) begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE waits for Run, MAC walks the inputs, ACT finishes
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (Run) state_next = ST_MAC;
         ST_MAC:  if (idx == IDX_LAST) state_next = ST_ACT;
         ST_ACT:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, accumulation and result/Done registration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         acc    <= '0;
         xr     <= '0;
         mode_r <= '0;
         y_r    <= '0;
         done_r <= 1'b0;
      end else if (En) begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Run) begin
                  xr     <= X;
                  mode_r <= Mode;
                  acc    <= ACC_INIT;
                  idx    <= '0;
               end
            end
            ST_MAC: begin
               acc <= acc + prod_ext;
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            ST_ACT: begin
               y_r    <= act_y;
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Busy = (state != ST_IDLE);
   assign Done = done_r;
   assign Y    = y_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with a scoreboard of expected Y values.
module tb_neuron_mac;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              run;
   logic [15:0]       x;
   logic [1:0]        mode;
   logic              busy;
   logic              done;
   logic signed [7:0] y;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int done_seen = 0;
   bit prev_done = 1'b0;

   typedef struct {
      int         x0;
      int         x1;
      logic [1:0] m;
      int         ey;
   } vec_t;

   vec_t vecs [10] = '{
      '{16, 16, 2'd0, 16},
      '{16, 16, 2'd2, 98},
      '{16, 16, 2'd3, 98},
      '{16, 16, 2'd1, 98},
      '{0, 0, 2'd0, 5},
      '{0, 0, 2'd1, 0},
      '{0, 0, 2'd2, -13},
      '{127, 127, 2'd2, 127},
      '{-128, -128, 2'd2, -128},
      '{-128, -128, 2'd0, 0}
   };

   neuron_mac #(
      .DATA_WIDTH (8),
      .FRAC_BITS  (4),
      .N_INPUTS   (2),
      .W          ({8'd60, 8'd51}),
      .BIAS       (-8'sd13)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .En    (en),
      .Run   (run),
      .X     (x),
      .Mode  (mode),
      .Busy  (busy),
      .Done  (done),
      .Y     (y)
   );

   always #5 clk = ~clk;

   // Reference: real-valued PLAN sigmoid and integer MAC with default weights
   function automatic int model_y(int x0, int x1, logic [1:0] m);
      int  acc;
      int  z;
      int  a;
      int  fi;
      real ar;
      real f;
      acc = x0*51 + x1*60 - 13*16;
      z = int'($floor(real'(acc) / 16.0));
      if (z > 127) z = 127;
      if (z < -128) z = -128;
      if (m == 2'd1) return (z < 0) ? 0 : z;
      if (m != 2'd0) return z;
      a  = (z < 0) ? -z : z;
      ar = real'(a) / 16.0;
      if (ar >= 5.0)        f = 1.0;
      else if (ar >= 2.375) f = ar/32.0 + 0.84375;
      else if (ar >= 1.0)   f = ar/8.0 + 0.625;
      else                  f = ar/4.0 + 0.5;
      fi = int'($floor(f * 16.0));
      if (fi > 16) fi = 16;
      return (z < 0) ? 16 - fi : fi;
   endfunction

   // Scoreboard: every rising Done pops and checks one expected result
   always @(posedge clk) begin
      #1;
      if (done && !prev_done) begin
         done_seen++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_done: got Y=%0d expected no Done", int'(y));
         end else begin
            automatic int e = exp_q.pop_front();
            if (int'(y) !== e) begin
               bad++;
               $display("[TB] FAIL scoreboard_y: got %0d expected %0d", int'(y), e);
            end
         end
      end
      prev_done = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int x0, input int x1, input logic [1:0] m);
      x    = {8'(x1), 8'(x0)};
      mode = m;
      run  = 1'b1;
      tick();
      run  = 1'b0;
      exp_q.push_back(model_y(x0, x1, m));
   endtask

   task automatic waitDone(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; run = 1'b0; x = '0; mode = 2'd0;
      #3;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      total++; if (y !== 8'sd0) begin bad++; $display("[TB] FAIL reset_y: got %0d expected 0", int'(y)); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_known_vectors();
      int c;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].x0, vecs[i].x1, vecs[i].m);
         waitDone(c);
         total++;
         if (c !== 3) begin bad++; $display("[TB] FAIL latency_vec%0d: got %0d expected 3", i, c); end
         total++;
         if (int'(y) !== vecs[i].ey) begin
            bad++; $display("[TB] FAIL known_vec%0d: got %0d expected %0d", i, int'(y), vecs[i].ey);
         end
      end
   endtask

   task automatic test_random();
      int c;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                       2'($urandom_range(3)));
         waitDone(c);
         total++;
         if (c !== 3) begin bad++; $display("[TB] FAIL latency_rand%0d: got %0d expected 3", i, c); end
      end
   endtask

   task automatic test_busy_profile();
      applyStimulus(2, 3, 2'd2);
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_edge0: got %b expected 1", busy); end
      tick();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL busy_edge1: got busy=%b done=%b expected 1 0", busy, done); end
      tick();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL busy_edge2: got busy=%b done=%b expected 1 0", busy, done); end
      tick();
      total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL busy_edge3: got busy=%b done=%b expected 0 1", busy, done); end
      tick();
   endtask

   task automatic test_run_during_busy();
      int c;
      int seen0 = done_seen;
      applyStimulus(10, -20, 2'd2);
      tick();
      x = {8'(99), 8'(-77)};
      mode = 2'd0;
      run = 1'b1;
      tick();
      run = 1'b0;
      waitDone(c);
      total++; if (c !== 1) begin bad++; $display("[TB] FAIL run_busy_latency: got %0d expected 1", c); end
      repeat (6) tick();
      total++;
      if (done_seen - seen0 !== 1) begin
         bad++; $display("[TB] FAIL run_busy_count: got %0d expected 1", done_seen - seen0);
      end
   endtask

   task automatic test_enable_stall();
      int c;
      logic signed [7:0] y_before;
      applyStimulus(3, 5, 2'd2);
      tick();
      y_before = y;
      en = 1'b0;
      repeat (3) tick();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL stall_state: got busy=%b done=%b expected 1 0", busy, done); end
      total++; if (y !== y_before) begin bad++; $display("[TB] FAIL stall_y: got %0d expected %0d", int'(y), int'(y_before)); end
      en = 1'b1;
      waitDone(c);
      total++; if (1 + 3 + c !== 6) begin bad++; $display("[TB] FAIL stall_latency: got %0d expected 6", 1 + 3 + c); end
   endtask

   task automatic test_done_hold();
      int c;
      applyStimulus(1, 2, 2'd0);
      waitDone(c);
      en = 1'b0;
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_hold1: got %b expected 1", done); end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_hold2: got %b expected 1", done); end
      en = 1'b1;
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_clear: got %b expected 0", done); end
   endtask

   task automatic test_reset_mid();
      int c;
      int seen0;
      applyStimulus(20, 30, 2'd2);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
      total++; if (y !== 8'sd0) begin bad++; $display("[TB] FAIL midreset_y: got %0d expected 0", int'(y)); end
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      seen0 = done_seen;
      repeat (4) tick();
      total++; if (done_seen !== seen0) begin bad++; $display("[TB] FAIL midreset_partial: got %0d dones expected 0", done_seen - seen0); end
      applyStimulus(5, 6, 2'd2);
      waitDone(c);
      total++; if (c !== 3) begin bad++; $display("[TB] FAIL midreset_rerun: got %0d expected 3", c); end
      total++; if (int'(y) !== 25) begin bad++; $display("[TB] FAIL midreset_y_rerun: got %0d expected 25", int'(y)); end
   endtask

   task automatic test_back_to_back();
      int c;
      run = 1'b1;
      x = {8'(4), 8'(4)}; mode = 2'd2;
      tick();
      exp_q.push_back(model_y(4, 4, 2'd2));
      x = {8'(-3), 8'(7)}; mode = 2'd1;
      tick(); tick(); tick();
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done1: got %b expected 1", done); end
      tick();
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_accept2: got busy=%b done=%b expected 1 0", busy, done); end
      exp_q.push_back(model_y(7, -3, 2'd1));
      x = {8'(2), 8'(-9)}; mode = 2'd0;
      tick(); tick(); tick();
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done2: got %b expected 1", done); end
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept3: got %b expected 1", busy); end
      exp_q.push_back(model_y(-9, 2, 2'd0));
      run = 1'b0;
      waitDone(c);
      total++; if (c !== 3) begin bad++; $display("[TB] FAIL b2b_latency3: got %0d expected 3", c); end
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_random();
      test_busy_profile();
      test_run_during_busy();
      test_enable_stall();
      test_done_hold();
      test_reset_mid();
      test_back_to_back();
      total++;
      if (exp_q.size() !== 0) begin
         bad++; $display("[TB] FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
